aerout_axis_tx: RTL and testbench

//  Transmit-side bridge from tinyODIN AER output to the UART AXI-Stream byte input; counterpart of axis_rx.

---
 rtl/odin_uart_pkg.sv | 27 ++
 rtl/aerout_axis_tx_if.sv | 12 +
 rtl/aer_event_fifo.sv | 60 ++++++
 rtl/aerout_axis_tx.sv | 164 ++++++++++++++++
 tb/tb_aerout_axis_tx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/odin_uart_pkg.sv
// Shared definitions for the tinyODIN AER-to-UART transmit bridge.
package odin_uart_pkg;

    localparam int unsigned AER_ADDR_W = 8;
    localparam int unsigned TS_W       = 8;
    localparam int unsigned EVT_W      = AER_ADDR_W + TS_W;

    // AER handshake side: waiting for a request, or holding the acknowledge
    typedef enum logic {
        A_IDLE = 1'b0,
        A_ACK  = 1'b1
    } aer_state_t;

    // Byte serialiser: idle, presenting the address byte, presenting the timestamp byte
    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_ADDR = 2'd1,
        T_TS   = 2'd2
    } tx_state_t;

    // One buffered event as stored in the FIFO
    typedef struct packed {
        logic [AER_ADDR_W-1:0] addr;
        logic [TS_W-1:0]       ts;
    } aer_evt_t;

endpackage

// File: rtl/aerout_axis_tx_if.sv
// Byte-wide AXI-Stream link from the bridge to the UART transmitter.
interface aerout_axis_tx_if;
    import odin_uart_pkg::*;

    logic [AER_ADDR_W-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/aer_event_fifo.sv
// Synchronous event FIFO with occupancy count; full/empty derived from the registered level.
module aer_event_fifo
    import odin_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = EVT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       rd_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [LW-1:0] level_q;
    logic          do_wr;
    logic          do_rd;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_wr   = wr_i && !full_o;
    assign do_rd   = rd_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

    // Storage array; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + AW'(1);
            if (do_rd) rptr_q <= rptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/aerout_axis_tx.sv
// tinyODIN AEROUT bridge: completes the 4-phase REQ/ACK handshake, timestamps and
// buffers each event, then serialises it to the UART as ADDR (and optionally TS) bytes.
module aerout_axis_tx
    import odin_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TS_DIV      = 850,
    parameter bit          EMIT_TS     = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AER_ADDR_W-1:0]         AEROUT_ADDR,
    input  logic                          AEROUT_REQ,
    output logic                          AEROUT_ACK,
    aerout_axis_tx_if.master              m_axis,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [EVT_W-1:0]              evt_count
);

    localparam int unsigned PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;

    logic                  req_s;
    logic [PW-1:0]         presc_q;
    logic [TS_W-1:0]       ts_q;
    logic                  ts_tick;

    aer_state_t            a_q, a_d;
    tx_state_t             t_q, t_d;
    logic [AER_ADDR_W-1:0] tdata_q, tdata_d;
    logic [EVT_W-1:0]      evt_cnt_q;

    logic                  fifo_wr;
    logic                  fifo_rd;
    logic                  fifo_full;
    logic                  fifo_empty;
    aer_evt_t              wr_evt;
    aer_evt_t              head;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign req_s = AEROUT_REQ;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            // REQ synchroniser; the cast drops the oldest bit so one stage also works
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_q <= '0;
                else     sync_q <= SYNC_STAGES'({sync_q, AEROUT_REQ});
            end
            assign req_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign ts_tick = (presc_q == PW'(TS_DIV - 1));

    // Prescaler and 8-bit timestamp counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            ts_q    <= '0;
        end else if (ts_tick) begin
            presc_q <= '0;
            ts_q    <= ts_q + TS_W'(1);
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // AER FSM state register and accepted-event counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= A_IDLE;
            evt_cnt_q <= '0;
        end else begin
            a_q <= a_d;
            if (fifo_wr) evt_cnt_q <= evt_cnt_q + EVT_W'(1);
        end
    end

    // AER FSM: one FIFO write per handshake, withheld while the FIFO is full
    always_comb begin
        a_d     = a_q;
        fifo_wr = 1'b0;
        unique case (a_q)
            A_IDLE: begin
                if (req_s && !fifo_full) begin
                    fifo_wr = 1'b1;
                    a_d     = A_ACK;
                end
            end
            A_ACK: begin
                if (!req_s) a_d = A_IDLE;
            end
        endcase
    end

    assign AEROUT_ACK  = (a_q == A_ACK);
    assign wr_evt.addr = AEROUT_ADDR;
    assign wr_evt.ts   = ts_q;

    aer_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (fifo_wr),
        .wdata_i (wr_evt),
        .rd_i    (fifo_rd),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // TX FSM state and registered output byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q     <= T_IDLE;
            tdata_q <= '0;
        end else begin
            t_q     <= t_d;
            tdata_q <= tdata_d;
        end
    end

    // TX FSM: the head entry stays in the FIFO until its last byte is accepted
    always_comb begin
        t_d     = t_q;
        tdata_d = tdata_q;
        fifo_rd = 1'b0;
        unique case (t_q)
            T_IDLE: begin
                if (!fifo_empty) begin
                    t_d     = T_ADDR;
                    tdata_d = head.addr;
                end
            end
            T_ADDR: begin
                if (m_axis.tready) begin
                    if (EMIT_TS) begin
                        t_d     = T_TS;
                        tdata_d = head.ts;
                    end else begin
                        fifo_rd = 1'b1;
                        t_d     = T_IDLE;
                    end
                end
            end
            T_TS: begin
                if (m_axis.tready) begin
                    fifo_rd = 1'b1;
                    t_d     = T_IDLE;
                end
            end
            default: t_d = T_IDLE;
        endcase
    end

    assign m_axis.tvalid = (t_q != T_IDLE);
    assign m_axis.tdata  = tdata_q;
    assign evt_count     = evt_cnt_q;

endmodule

// File: tb/tb_aerout_axis_tx.sv
// Self-checking bench for aerout_axis_tx: directed handshake scenarios plus a randomized phase,
// checked against a byte-stream model built from observed handshakes and the tick arithmetic.
`timescale 1ns/1ps
module tb_aerout_axis_tx;
    import odin_uart_pkg::*;

    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned TS_DIV     = 4;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [7:0]                   AEROUT_ADDR = '0;
    logic                         AEROUT_REQ  = 1'b0;
    logic                         AEROUT_ACK;
    logic [$clog2(FIFO_DEPTH):0]  fifo_level;
    logic [15:0]                  evt_count;
    logic                         rdy      = 1'b0;
    logic                         rdy_rnd  = 1'b0;
    logic                         rand_rdy = 1'b0;

    aerout_axis_tx_if m_axis();
    assign m_axis.tready = rand_rdy ? rdy_rnd : rdy;

    aerout_axis_tx #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (2),
        .TS_DIV      (TS_DIV),
        .EMIT_TS     (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .AEROUT_ADDR (AEROUT_ADDR),
        .AEROUT_REQ  (AEROUT_REQ),
        .AEROUT_ACK  (AEROUT_ACK),
        .m_axis      (m_axis),
        .fifo_level  (fifo_level),
        .evt_count   (evt_count)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned cyc;
    int unsigned exp_evt = 0;
    int unsigned rise_cyc;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_log[$];
    logic        prev_ack = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_tdata = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Clock edges since reset release; edge e samples ts = floor((e-1)/TS_DIV) mod 256
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        #1 rdy_rnd = 1'($urandom_range(0, 1));
    end

    // Reference model and stream monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_ack   = 1'b0;
            prev_stall = 1'b0;
            exp_q.delete();
        end else begin
            if (AEROUT_ACK && !prev_ack) begin
                exp_q.push_back(AEROUT_ADDR);
                exp_q.push_back(8'((cyc - 1) / TS_DIV));
            end
            prev_ack = AEROUT_ACK;
            if (prev_stall) begin
                chk("hold_valid", 32'(m_axis.tvalid), 32'd1);
                chk("hold_data", 32'(m_axis.tdata), 32'(prev_tdata));
            end
            if (m_axis.tvalid && m_axis.tready) begin
                rx_log.push_back(m_axis.tdata);
                if (exp_q.size() == 0) chk("byte_extra", 32'(exp_q.size()), 32'd1);
                else                   chk("byte", 32'(m_axis.tdata), 32'(exp_q.pop_front()));
            end
            prev_stall = m_axis.tvalid && !m_axis.tready;
            prev_tdata = m_axis.tdata;
        end
    end

    task automatic aer_push(input logic [7:0] a, input int unsigned hold, input int unsigned bound);
        int unsigned n;
        @(posedge clk); #1;
        AEROUT_ADDR = a;
        AEROUT_REQ  = 1'b1;
        rise_cyc    = cyc;
        n = 0;
        while (!AEROUT_ACK && n < bound) begin @(negedge clk); n++; end
        chk("ack_rise", 32'(AEROUT_ACK), 32'd1);
        if (AEROUT_ACK) exp_evt++;
        repeat (hold) @(negedge clk);
        if (hold > 0) chk("ack_held", 32'(AEROUT_ACK), 32'd1);
        @(posedge clk); #1;
        AEROUT_REQ = 1'b0;
        n = 0;
        while (AEROUT_ACK && n < 20) begin @(negedge clk); n++; end
        chk("ack_fall", 32'(AEROUT_ACK), 32'd0);
    endtask

    task automatic drain();
        int unsigned n;
        @(posedge clk); #1;
        rand_rdy = 1'b0;
        rdy      = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || m_axis.tvalid) && n < 1000) begin @(negedge clk); n++; end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_level", 32'(fifo_level), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int unsigned base, ts_a, ts_b;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(AEROUT_ACK), 32'd0);
        chk("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
        chk("rst_tdata", 32'(m_axis.tdata), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_evt", 32'(evt_count), 32'd0);
        rst = 1'b0;

        // 1: single event, ACK latency through the two-stage synchroniser
        @(posedge clk); #1;
        rdy = 1'b1; AEROUT_ADDR = 8'h2A; AEROUT_REQ = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_ack_lat_lo", 32'(AEROUT_ACK), 32'd0);
        @(negedge clk);
        chk("t1_ack_lat_hi", 32'(AEROUT_ACK), 32'd1);
        exp_evt++;
        @(posedge clk); #1;
        AEROUT_REQ = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_ack_fall_lo", 32'(AEROUT_ACK), 32'd1);
        @(negedge clk);
        chk("t1_ack_fall_hi", 32'(AEROUT_ACK), 32'd0);
        drain();
        chk("t1_evt", 32'(evt_count), 32'd1);
        chk("t1_addr", 32'(rx_log[0]), 32'h2A);
        chk("t1_bytes", 32'(rx_log.size()), 32'd2);

        // 2: stalled sink keeps the byte presented
        rdy = 1'b0;
        aer_push(8'h2A, 0, 50);
        repeat (20) @(negedge clk);
        chk("t2_tvalid", 32'(m_axis.tvalid), 32'd1);
        chk("t2_tdata", 32'(m_axis.tdata), 32'h2A);
        drain();

        // 3: fill the FIFO, 17th request held off until the first pop
        rdy = 1'b0;
        base = rx_log.size();
        for (int i = 0; i < 16; i++) aer_push(8'(i), 0, 50);
        chk("t3_level_full", 32'(fifo_level), 32'd16);
        @(posedge clk); #1;
        AEROUT_ADDR = 8'h10; AEROUT_REQ = 1'b1;
        repeat (30) @(negedge clk);
        chk("t3_backpressure", 32'(AEROUT_ACK), 32'd0);
        chk("t3_evt", 32'(evt_count), 32'(exp_evt));
        @(posedge clk); #1;
        rdy = 1'b1;
        for (int n = 0; n < 50 && !AEROUT_ACK; n++) @(negedge clk);
        chk("t3_ack_after_pop", 32'(AEROUT_ACK), 32'd1);
        if (AEROUT_ACK) exp_evt++;
        @(posedge clk); #1;
        AEROUT_REQ = 1'b0;
        drain();
        for (int i = 0; i < 17; i++)
            chk("t3_order", 32'(rx_log[base + 2 * i]), 32'(i));

        // 4: long REQ produces exactly one event
        aer_push(8'h77, 50, 50);
        chk("t4_evt", 32'(evt_count), 32'(exp_evt));
        drain();

        // 5: reset in the middle of a timestamp byte with three events queued
        rdy = 1'b0;
        aer_push(8'h31, 0, 50);
        aer_push(8'h32, 0, 50);
        aer_push(8'h33, 0, 50);
        @(posedge clk); #1; rdy = 1'b1;
        @(posedge clk); #1; rdy = 1'b0;
        @(negedge clk);
        chk("t5_ts_pending", 32'(m_axis.tvalid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t5_ack", 32'(AEROUT_ACK), 32'd0);
        chk("t5_tvalid", 32'(m_axis.tvalid), 32'd0);
        chk("t5_level", 32'(fifo_level), 32'd0);
        chk("t5_evt", 32'(evt_count), 32'd0);
        exp_evt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rdy = 1'b1;
        base = rx_log.size();
        aer_push(8'h55, 0, 50);
        drain();
        chk("t5_post_addr", 32'(rx_log[base]), 32'h55);
        chk("t5_post_bytes", 32'(rx_log.size() - base), 32'd2);
        chk("t5_post_evt", 32'(evt_count), 32'd1);

        // 6: timestamp spacing
        base = rx_log.size();
        aer_push(8'hA0, 0, 50);
        while (cyc < rise_cyc + 1023) begin @(posedge clk); #1; end
        aer_push(8'hA1, 0, 50);
        drain();
        ts_a = rx_log[base + 1];
        ts_b = rx_log[base + 3];
        chk("t6_gap1024", 32'(8'(ts_b - ts_a)), 32'd0);
        base = rx_log.size();
        aer_push(8'hB0, 0, 50);
        while (cyc < rise_cyc + 39) begin @(posedge clk); #1; end
        aer_push(8'hB1, 0, 50);
        drain();
        ts_a = rx_log[base + 1];
        ts_b = rx_log[base + 3];
        chk("t6_gap40", 32'(8'(ts_b - ts_a)), 32'd10);

        // Randomized traffic with random sink readiness
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 15)) @(posedge clk);
            aer_push(8'($urandom), $urandom_range(0, 3), 400);
        end
        drain();
        chk("rand_evt", 32'(evt_count), 32'(exp_evt));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
